// File: rtl/gray_stream_if.sv
// Word stream bundle between a Gray-code source and gray_stream_monitor.
interface gray_stream_if;
  logic        i_vld;
  logic [7:0]  i_gray;
  logic        i_clr;
  logic        o_vld;
  logic [7:0]  o_bin;
  logic        o_step_err;
  logic        o_lock;
  logic        o_lost;
  logic [15:0] o_err_cnt;
  logic [15:0] o_word_cnt;

  modport master (
    output i_vld, i_gray, i_clr,
    input  o_vld, o_bin, o_step_err, o_lock, o_lost, o_err_cnt, o_word_cnt
  );

  modport slave (
    input  i_vld, i_gray, i_clr,
    output o_vld, o_bin, o_step_err, o_lock, o_lost, o_err_cnt, o_word_cnt
  );
endinterface

// File: rtl/gray_stream_monitor.sv
// Decodes a Gray-coded counter stream, checks for +1 steps and tracks lock
// with an IDLE/ACQ/LOCK state machine; all outputs are registered.
module gray_stream_monitor #(
  parameter int unsigned LOCK_LEN = 4,
  parameter int unsigned GAP_MAX  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  gray_stream_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_LEN);
  localparam logic [7:0] GAP_C  = 8'(GAP_MAX);

  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int k = 6; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state_r, state_nx;
  logic [3:0]  run_r, run_nx;
  logic [7:0]  gap_r, gap_nx;
  logic [7:0]  prev_r, prev_nx;
  logic        vld_r, vld_nx;
  logic [7:0]  bin_r, bin_nx;
  logic        step_err_r, step_err_nx;
  logic        lock_r, lock_nx;
  logic        lost_r, lost_nx;
  logic [15:0] err_cnt_r, err_cnt_nx;
  logic [15:0] word_cnt_r, word_cnt_nx;
  logic [7:0]  bin_s;
  logic        good_s;

  assign bin_s  = gray2bin(bus.i_gray);
  assign good_s = (bin_s == prev_r + 8'd1);

  // Register all state and outputs; reset is asynchronous and active-high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r    <= ST_IDLE;
      run_r      <= 4'd0;
      gap_r      <= 8'd0;
      prev_r     <= 8'd0;
      vld_r      <= 1'b0;
      bin_r      <= 8'd0;
      step_err_r <= 1'b0;
      lock_r     <= 1'b0;
      lost_r     <= 1'b0;
      err_cnt_r  <= 16'd0;
      word_cnt_r <= 16'd0;
    end else begin
      state_r    <= state_nx;
      run_r      <= run_nx;
      gap_r      <= gap_nx;
      prev_r     <= prev_nx;
      vld_r      <= vld_nx;
      bin_r      <= bin_nx;
      step_err_r <= step_err_nx;
      lock_r     <= lock_nx;
      lost_r     <= lost_nx;
      err_cnt_r  <= err_cnt_nx;
      word_cnt_r <= word_cnt_nx;
    end
  end

  // Next-state and next-output logic; i_clr overrides any word or gap event.
  always_comb begin
    state_nx    = state_r;
    run_nx      = run_r;
    gap_nx      = gap_r;
    prev_nx     = prev_r;
    vld_nx      = 1'b0;
    bin_nx      = bin_r;
    step_err_nx = 1'b0;
    lost_nx     = 1'b0;
    err_cnt_nx  = err_cnt_r;
    word_cnt_nx = word_cnt_r;

    if (bus.i_clr) begin
      state_nx    = ST_IDLE;
      run_nx      = 4'd0;
      gap_nx      = 8'd0;
      bin_nx      = 8'd0;
      err_cnt_nx  = 16'd0;
      word_cnt_nx = 16'd0;
    end else if (bus.i_vld) begin
      gap_nx      = 8'd0;
      vld_nx      = 1'b1;
      bin_nx      = bin_s;
      prev_nx     = bin_s;
      word_cnt_nx = sat_inc16(word_cnt_r);
      case (state_r)
        ST_IDLE: begin
          run_nx   = 4'd0;
          state_nx = ST_ACQ;
        end
        ST_ACQ: begin
          if (good_s) begin
            run_nx = run_r + 4'd1;
            if (run_r + 4'd1 == LOCK_C) begin
              state_nx = ST_LOCK;
            end else begin
              state_nx = ST_ACQ;
            end
          end else begin
            run_nx      = 4'd0;
            step_err_nx = 1'b1;
            err_cnt_nx  = sat_inc16(err_cnt_r);
          end
        end
        ST_LOCK: begin
          if (good_s) begin
            state_nx = ST_LOCK;
          end else begin
            run_nx      = 4'd0;
            step_err_nx = 1'b1;
            lost_nx     = 1'b1;
            err_cnt_nx  = sat_inc16(err_cnt_r);
            state_nx    = ST_ACQ;
          end
        end
        default: begin
          run_nx   = 4'd0;
          state_nx = ST_IDLE;
        end
      endcase
    end else begin
      // Gap counter saturates so a long silence in IDLE cannot wrap.
      gap_nx = (gap_r == 8'hFF) ? gap_r : gap_r + 8'd1;
      if ((gap_nx >= GAP_C) && (state_r != ST_IDLE)) begin
        state_nx = ST_IDLE;
        run_nx   = 4'd0;
      end else begin
        state_nx = state_r;
      end
    end

    lock_nx = (state_nx == ST_LOCK);
  end

  assign bus.o_vld      = vld_r;
  assign bus.o_bin      = bin_r;
  assign bus.o_step_err = step_err_r;
  assign bus.o_lock     = lock_r;
  assign bus.o_lost     = lost_r;
  assign bus.o_err_cnt  = err_cnt_r;
  assign bus.o_word_cnt = word_cnt_r;

endmodule

// File: tb/tb_gray_stream_monitor.sv
// Directed bench for gray_stream_monitor with hand-computed expectations.
module tb_gray_stream_monitor;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  gray_stream_if bus ();

  gray_stream_monitor #(.LOCK_LEN(4), .GAP_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_gray(input int v);
    logic [7:0] b;
    b = 8'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one input cycle, then sample just after the capturing edge.
  task automatic step(input logic vld, input logic [7:0] g, input logic clr);
    @(negedge clk);
    bus.i_vld  = vld;
    bus.i_gray = g;
    bus.i_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vld"},  32'(bus.o_vld), 32'd0);
    chk({tag, "_bin"},  32'(bus.o_bin), 32'd0);
    chk({tag, "_serr"}, 32'(bus.o_step_err), 32'd0);
    chk({tag, "_lock"}, 32'(bus.o_lock), 32'd0);
    chk({tag, "_lost"}, 32'(bus.o_lost), 32'd0);
    chk({tag, "_ecnt"}, 32'(bus.o_err_cnt), 32'd0);
    chk({tag, "_wcnt"}, 32'(bus.o_word_cnt), 32'd0);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    clk        = 1'b0;
    rst_n      = 1'b1;
    bus.i_vld  = 1'b0;
    bus.i_gray = 8'd0;
    bus.i_clr  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b0;

    // Continuous count 0..255: lock rises with o_bin=4
    for (int i = 0; i < 256; i++) begin
      step(1'b1, to_gray(i), 1'b0);
      chk("run_vld",  32'(bus.o_vld), 32'd1);
      chk("run_bin",  32'(bus.o_bin), 32'(i));
      chk("run_serr", 32'(bus.o_step_err), 32'd0);
      chk("run_lock", 32'(bus.o_lock), (i >= 4) ? 32'd1 : 32'd0);
    end
    chk("run_ecnt", 32'(bus.o_err_cnt), 32'd0);
    chk("run_wcnt", 32'(bus.o_word_cnt), 32'd256);

    // Clear together with a bad-step word while locked
    step(1'b1, to_gray(7), 1'b1);
    chk_all_zero("clr");

    // Re-lock at 252, then cross the 255->0 wrap
    for (int i = 248; i <= 252; i++) begin
      step(1'b1, to_gray(i), 1'b0);
      chk("relock_lock", 32'(bus.o_lock), (i == 252) ? 32'd1 : 32'd0);
    end
    for (int i = 253; i <= 257; i++) begin
      step(1'b1, to_gray(i % 256), 1'b0);
      chk("wrap_bin",  32'(bus.o_bin), 32'(i % 256));
      chk("wrap_serr", 32'(bus.o_step_err), 32'd0);
      chk("wrap_lock", 32'(bus.o_lock), 32'd1);
    end
    chk("wrap_wcnt", 32'(bus.o_word_cnt), 32'd10);

    // Locked skip 10 -> 12 loses lock; 13..16 re-acquire
    for (int i = 2; i <= 10; i++) begin
      step(1'b1, to_gray(i), 1'b0);
    end
    chk("pre_skip_lock", 32'(bus.o_lock), 32'd1);
    step(1'b1, to_gray(12), 1'b0);
    chk("skip_bin",  32'(bus.o_bin), 32'd12);
    chk("skip_serr", 32'(bus.o_step_err), 32'd1);
    chk("skip_lost", 32'(bus.o_lost), 32'd1);
    chk("skip_lock", 32'(bus.o_lock), 32'd0);
    chk("skip_ecnt", 32'(bus.o_err_cnt), 32'd1);
    for (int i = 13; i <= 16; i++) begin
      step(1'b1, to_gray(i), 1'b0);
      chk("reacq_serr", 32'(bus.o_step_err), 32'd0);
      chk("reacq_lost", 32'(bus.o_lost), 32'd0);
      chk("reacq_lock", 32'(bus.o_lock), (i == 16) ? 32'd1 : 32'd0);
    end
    chk("reacq_wcnt", 32'(bus.o_word_cnt), 32'd24);

    // Eight idle cycles drop to IDLE without o_lost; gray ignored while idle
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'hA5, 1'b0);
      chk("gap_vld",  32'(bus.o_vld), 32'd0);
      chk("gap_lost", 32'(bus.o_lost), 32'd0);
      chk("gap_lock", 32'(bus.o_lock), (i < 8) ? 32'd1 : 32'd0);
    end
    chk("gap_wcnt", 32'(bus.o_word_cnt), 32'd24);
    step(1'b1, to_gray(99), 1'b0);
    chk("gap_cap_vld",  32'(bus.o_vld), 32'd1);
    chk("gap_cap_bin",  32'(bus.o_bin), 32'd99);
    chk("gap_cap_serr", 32'(bus.o_step_err), 32'd0);
    chk("gap_cap_lock", 32'(bus.o_lock), 32'd0);
    chk("gap_cap_ecnt", 32'(bus.o_err_cnt), 32'd1);

    // Asynchronous reset pulse between edges
    step(1'b1, to_gray(100), 1'b0);
    chk("pre_rst_wcnt", 32'(bus.o_word_cnt), 32'd26);
    @(negedge clk);
    bus.i_vld = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    chk_all_zero("async_rst");
    rst_n = 1'b0;
    step(1'b1, to_gray(50), 1'b0);
    chk("post_rst_vld",  32'(bus.o_vld), 32'd1);
    chk("post_rst_bin",  32'(bus.o_bin), 32'd50);
    chk("post_rst_serr", 32'(bus.o_step_err), 32'd0);
    chk("post_rst_wcnt", 32'(bus.o_word_cnt), 32'd1);
    step(1'b1, to_gray(51), 1'b0);
    chk("post_rst_serr2", 32'(bus.o_step_err), 32'd0);
    chk("post_rst_ecnt",  32'(bus.o_err_cnt), 32'd0);
    step(1'b0, 8'd0, 1'b0);
    chk("post_rst_idle_vld", 32'(bus.o_vld), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
